// File: rtl/aes128_enc_scheduler.sv
// Round-robin front end that time-shares one external combinational AES-128 core.
// Optional build macro AES_SCHED_ZEROIZE_EN clears core operands on each response handshake.
module aes128_enc_scheduler #(
    parameter int unsigned LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [0:127] req0_pt,
    input  logic [0:127] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [0:127] req1_pt,
    input  logic [0:127] req1_key,
    output logic [0:127] core_pt,
    output logic [0:127] core_key,
    input  logic [0:127] core_ct,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [0:127] rsp_ct,
    output logic         rsp_id,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   r_state;
    logic [7:0]   r_cnt;
    logic         r_last_grant;
    logic [0:127] r_core_pt;
    logic [0:127] r_core_key;
    logic [0:127] r_rsp_ct;
    logic         r_rsp_valid;
    logic         r_rsp_id;

    logic         w_idle;
    logic         w_any_valid;
    logic         w_grant;
    logic [0:127] w_sel_pt;
    logic [0:127] w_sel_key;

    assign w_idle      = (r_state == S_IDLE);
    assign w_any_valid = req0_valid | req1_valid;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_sel_pt  = w_grant ? req1_pt  : req0_pt;
    assign w_sel_key = w_grant ? req1_key : req0_key;

    // rst_n gates the readies so nothing looks accepted while reset is held.
    assign req0_ready = rst_n & w_idle & req0_valid & ~w_grant;
    assign req1_ready = rst_n & w_idle & req1_valid &  w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_core_pt    <= '0;
            r_core_key   <= '0;
            r_rsp_ct     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_core_pt    <= w_sel_pt;
                        r_core_key   <= w_sel_key;
                        r_rsp_id     <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= 8'(LATENCY - 1);
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Core output is a multicycle path; sample only once the count expires.
                    if (r_cnt == '0) begin
                        r_rsp_ct    <= core_ct;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
`ifdef AES_SCHED_ZEROIZE_EN
                        r_core_pt   <= '0;
                        r_core_key  <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_pt   = r_core_pt;
    assign core_key  = r_core_key;
    assign rsp_valid = r_rsp_valid;
    assign rsp_ct    = r_rsp_ct;
    assign rsp_id    = r_rsp_id;
    assign busy      = ~w_idle;

endmodule

// File: tb/tb_aes128_enc_scheduler.sv
// Bench for aes128_enc_scheduler: behavioural AES core, known-answer table, directed corner
// sequences and randomized traffic checked by a cycle-level model of the arbitration rules.
module tb_aes128_enc_scheduler;

    localparam int unsigned LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_pt = '0, req0_key = '0, req1_pt = '0, req1_key = '0;
    logic [127:0] core_pt, core_key, core_ct;
    logic         rsp_valid, rsp_id, busy;
    logic         rsp_ready = 1'b1;
    logic [127:0] rsp_ct;

    always #5 clk = ~clk;

    aes128_enc_scheduler #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pt(req0_pt), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pt(req1_pt), .req1_key(req1_key),
        .core_pt(core_pt), .core_key(core_key), .core_ct(core_ct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct), .rsp_id(rsp_id), .busy(busy)
    );

    // ---------------- behavioural AES-128 ----------------
    logic [7:0] sbox [256];
    bit         sbox_done = 1'b0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0, x = a, y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] n [16];
        logic [7:0] k [16];
        logic [7:0] rc, t0, t1, t2, t3, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            t0 = sbox[k[13]] ^ rc; t1 = sbox[k[14]]; t2 = sbox[k[15]]; t3 = sbox[k[12]];
            k[0] ^= t0; k[1] ^= t1; k[2] ^= t2; k[3] ^= t3;
            for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    n[j+4*c] = s[j+4*((c+j)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // external core model: purely combinational from the registered operands
    always @(core_pt or core_key or sbox_done) core_ct = aes_enc(core_pt, core_key);

    // ---------------- bookkeeping ----------------
    typedef struct { logic [127:0] pt; logic [127:0] key; } op_t;
    typedef struct { logic [127:0] pt; logic [127:0] key; bit id; logic [127:0] ct; } vec_t;
    typedef struct { logic [127:0] ct; bit id; } rsp_t;

    op_t         q0[$], q1[$];
    rsp_t        rsp_log[$];
    int unsigned acc_edge[$], rise_cyc[$];
    bit          acc_id[$];

    int unsigned vecs = 0, errs = 0, cyc = 0;
    bit rnd_valid = 1'b0, rnd_rsp = 1'b0, rsp_hold = 1'b1;
    bit acc0 = 1'b0, acc1 = 1'b0, prev_rv = 1'b0;

    int          m_phase = 0;          // 0 idle, 1 computing, 2 holding response
    int unsigned m_left = 0;
    bit          m_last = 1'b1, m_id = 1'b0;
    logic [127:0] m_pt = '0, m_key = '0, m_ct = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_cycle();
        bit w, e0, e1;
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_last = 1'b1; m_id = 1'b0;
            m_pt = '0; m_key = '0; m_ct = '0;
        end
        w  = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e0 = rst_n && m_phase == 0 && req0_valid && !w;
        e1 = rst_n && m_phase == 0 && req1_valid && w;
        chk("req0_ready", 128'(req0_ready), 128'(e0));
        chk("req1_ready", 128'(req1_ready), 128'(e1));
        chk("busy",       128'(busy),       128'(m_phase != 0));
        chk("rsp_valid",  128'(rsp_valid),  128'(m_phase == 2));
        chk("rsp_id",     128'(rsp_id),     128'(m_id));
        chk("rsp_ct",     rsp_ct,   m_ct);
        chk("core_pt",    core_pt,  m_pt);
        chk("core_key",   core_key, m_key);
        if (rsp_valid && !prev_rv) rise_cyc.push_back(cyc);
        prev_rv = rsp_valid;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (rst_n) begin
            case (m_phase)
                0: if (req0_valid || req1_valid) begin
                    m_id = w; m_last = w;
                    m_pt  = w ? req1_pt  : req0_pt;
                    m_key = w ? req1_key : req0_key;
                    m_left = LAT; m_phase = 1;
                    acc_edge.push_back(cyc + 1);
                    acc_id.push_back(w);
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_ct = aes_enc(m_pt, m_key);
                        m_phase = 2;
                    end
                end
                default: if (rsp_ready) begin
                    rsp_log.push_back('{ct: rsp_ct, id: rsp_id});
                    m_phase = 0;
`ifdef AES_SCHED_ZEROIZE_EN
                    m_pt = '0; m_key = '0;
`endif
                end
            endcase
        end
    endtask

    always @(negedge clk) model_cycle();

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0 && q0.size() > 0) q0.delete(0);
        if (acc1 && q1.size() > 0) q1.delete(0);
        acc0 = 1'b0; acc1 = 1'b0;
        req0_valid = (q0.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        req1_valid = (q1.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        req0_pt  = (q0.size() > 0) ? q0[0].pt  : rnd128();
        req0_key = (q0.size() > 0) ? q0[0].key : rnd128();
        req1_pt  = (q1.size() > 0) ? q1[0].pt  : rnd128();
        req1_key = (q1.size() > 0) ? q1[0].key : rnd128();
        rsp_ready = rnd_rsp ? 1'($urandom_range(0, 1)) : rsp_hold;
        #1;
    endtask

    task automatic run_drain(input int unsigned budget);
        bit done = 1'b0;
        for (int unsigned i = 0; i < budget && !done; i++) begin
            step();
            done = (q0.size() == 0) && (q1.size() == 0) && (m_phase == 0);
        end
        chk("drain_done", 128'(done), 128'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench watchdog expired");
    end

    vec_t        tv [3];
    int unsigned n_rsp, n_acc, n_rise;
    logic [127:0] hold_pt, hold_key;

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        sbox_done = 1'b1;

        tv[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  id: 1'b0, ct: 128'h3925841d02dc09fbdc118597196a0b32};
        tv[1] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                  id: 1'b1, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        tv[2] = '{pt: 128'h0, key: 128'h0, id: 1'b0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",      128'(busy),       128'd0);
        chk("reset_rsp_valid", 128'(rsp_valid),  128'd0);
        chk("reset_rsp_ct",    rsp_ct,           128'd0);
        chk("reset_core_key",  core_key,         128'd0);
        rst_n = 1'b1;

        // known-answer table: ciphertext, id, latency, operand retention/zeroize
        for (int i = 0; i < 3; i++) begin
            n_rsp = rsp_log.size(); n_acc = acc_edge.size(); n_rise = rise_cyc.size();
            rsp_hold = 1'b1;
            if (tv[i].id) q1.push_back('{pt: tv[i].pt, key: tv[i].key});
            else          q0.push_back('{pt: tv[i].pt, key: tv[i].key});
            run_drain(60);
            chk("kat_rsp_count", 128'(rsp_log.size()), 128'(n_rsp + 1));
            if (rsp_log.size() > n_rsp) begin
                chk("kat_ct", rsp_log[n_rsp].ct, tv[i].ct);
                chk("kat_id", 128'(rsp_log[n_rsp].id), 128'(tv[i].id));
            end
            if (rise_cyc.size() > n_rise && acc_edge.size() > n_acc)
                chk("kat_latency", 128'(rise_cyc[n_rise] - acc_edge[n_acc]), 128'(LAT));
`ifdef AES_SCHED_ZEROIZE_EN
            chk("zeroize_pt",  core_pt,  128'd0);
            chk("zeroize_key", core_key, 128'd0);
`else
            chk("retain_pt",  core_pt,  tv[i].pt);
            chk("retain_key", core_key, tv[i].key);
`endif
            chk("retain_rsp_ct", rsp_ct, tv[i].ct);
        end

        // both requesters saturated: alternating grants, fixed accept spacing
        do_reset();
        n_acc = acc_edge.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{pt: rnd128(), key: rnd128()});
            q1.push_back('{pt: rnd128(), key: rnd128()});
        end
        run_drain(200);
        chk("rr_accepts", 128'(acc_edge.size()), 128'(n_acc + 8));
        for (int k = 0; k < 8; k++) begin
            if (acc_id.size() > n_acc + k)
                chk("rr_grant_id", 128'(acc_id[n_acc + k]), 128'(k % 2));
            if (k > 0 && acc_edge.size() > n_acc + k)
                chk("rr_spacing", 128'(acc_edge[n_acc + k] - acc_edge[n_acc + k - 1]), 128'(LAT + 2));
        end

        // response back-pressure: outputs held, requesters locked out
        hold_pt = rnd128(); hold_key = rnd128();
        rsp_hold = 1'b0;
        q0.push_back('{pt: hold_pt, key: hold_key});
        for (int i = 0; i < 40 && !rsp_valid; i++) step();
        chk("bp_reached_done", 128'(rsp_valid), 128'd1);
        q0.push_back('{pt: rnd128(), key: rnd128()});
        q1.push_back('{pt: rnd128(), key: rnd128()});
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_rsp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_rsp_ct",    rsp_ct, aes_enc(hold_pt, hold_key));
            chk("bp_rsp_id",    128'(rsp_id), 128'd0);
            chk("bp_readies",   128'({req0_ready, req1_ready}), 128'd0);
            chk("bp_busy",      128'(busy), 128'd1);
        end
        rsp_hold = 1'b1;
        run_drain(100);

        // reset while waiting on the core: operation dropped, tie priority restored
        q0.push_back('{pt: rnd128(), key: rnd128()});
        run_drain(60);
        q0.push_back('{pt: rnd128(), key: rnd128()});
        for (int i = 0; i < 20 && !busy; i++) step();
        chk("rst_mid_busy_before", 128'(busy && !rsp_valid), 128'd1);
        n_rsp = rsp_log.size();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",      128'(busy),      128'd0);
        chk("rst_mid_rsp_valid", 128'(rsp_valid), 128'd0);
        step();
        rst_n = 1'b1;
        repeat (LAT + 4) step();
        chk("rst_mid_no_rsp", 128'(rsp_log.size()), 128'(n_rsp));
        n_acc = acc_id.size();
        q0.push_back('{pt: rnd128(), key: rnd128()});
        q1.push_back('{pt: rnd128(), key: rnd128()});
        run_drain(60);
        if (acc_id.size() > n_acc) chk("rst_tie_winner", 128'(acc_id[n_acc]), 128'd0);
        else chk("rst_tie_accepts", 128'(acc_id.size()), 128'(n_acc + 2));

        // randomized traffic with sporadic valid drops and back-pressure
        n_rsp = rsp_log.size();
        rnd_valid = 1'b1; rnd_rsp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q0.push_back('{pt: rnd128(), key: rnd128()});
            q1.push_back('{pt: rnd128(), key: rnd128()});
        end
        run_drain(2000);
        chk("rand_rsp_count", 128'(rsp_log.size()), 128'(n_rsp + 20));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
